// File: rtl/mc_datapath.sv
// Multicycle MIPS-subset datapath and controller with a single unified memory port.
// Executes add/sub/and/or/slt, lw, sw, beq, addi and j using shared ALU and IR/MDR/A/B/ALUOut registers.
module mc_datapath #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned ADDR_W          = 32,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc,
    output logic [3:0]        state,
    output logic              halted
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    state_t      cur, nxt;
    logic [31:0] ir, mdr, a, b, alu_out;
    logic [31:0] rf [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sext, alu_res, addr_full;
    logic        funct_ok;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};

    always_comb begin
        funct_ok = 1'b1;
        alu_res  = '0;
        case (funct)
            6'h20:   alu_res = a + b;
            6'h22:   alu_res = a - b;
            6'h24:   alu_res = a & b;
            6'h25:   alu_res = a | b;
            6'h2A:   alu_res = {31'd0, $signed(a) < $signed(b)};
            default: funct_ok = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur <= S_FETCH;
        else        cur <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = cur;
        case (cur)
            S_FETCH:  if (mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: nxt = funct_ok ? S_EXEC
                                             : (TRAP_ON_ILLEGAL ? S_HALT : S_FETCH);
                    OP_LW,
                    OP_SW:    nxt = S_MEMADR;
                    OP_BEQ:   nxt = S_BRANCH;
                    OP_ADDI:  nxt = S_ADDIEX;
                    OP_J:     nxt = S_JUMP;
                    default:  nxt = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR: nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
            S_MEMWR:  if (mem_ready) nxt = S_FETCH;
            S_EXEC:   nxt = S_ALUWB;
            S_ADDIEX: nxt = S_ADDIWB;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_FETCH;
        endcase
    end

    // Outputs; gating with reset drops the request asynchronously mid-access
    always_comb begin
        mem_req   = reset && (cur == S_FETCH || cur == S_MEMRD || cur == S_MEMWR);
        mem_we    = reset && (cur == S_MEMWR);
        addr_full = (cur == S_FETCH) ? pc : alu_out;
        mem_addr  = addr_full[ADDR_W-1:0];
        mem_wdata = b;
        halted    = (cur == S_HALT);
        state     = cur;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            mdr     <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (cur)
                S_FETCH: if (mem_ready) begin
                    ir <= mem_rdata;
                    pc <= pc + 32'd4;
                end
                S_DECODE: begin
                    a       <= rf[rs];
                    b       <= rf[rt];
                    alu_out <= pc + {imm_sext[29:0], 2'b00};
                end
                S_MEMADR, S_ADDIEX: alu_out <= a + imm_sext;
                S_MEMRD:  if (mem_ready) mdr <= mem_rdata;
                S_MEMWB:  if (rt != 5'd0) rf[rt] <= mdr;
                S_EXEC:   alu_out <= alu_res;
                S_ALUWB:  if (rd != 5'd0) rf[rd] <= alu_out;
                S_ADDIWB: if (rt != 5'd0) rf[rt] <= alu_out;
                S_BRANCH: if (a == b) pc <= alu_out;
                S_JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
                default:  ;
            endcase
        end
    end

endmodule

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: ADDR_W, 32, width of mem_addr (2..32); mem_addr = low ADDR_W bits of the byte address.
REQ-003 Parameter: TRAP_ON_ILLEGAL, 1, 1 = illegal opcode/funct enters HALT; 0 = treated as NOP.
REQ-004 Single clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 mem_req  output  1  memory access request, held until mem_ready.
REQ-008 mem_we  output  1  1 = write, 0 = read; valid while mem_req = 1.
REQ-009 mem_addr  output  ADDR_W  byte address.
REQ-010 mem_wdata  output  32  store data.
REQ-011 mem_rdata  input  32  read data; valid in the cycle mem_ready = 1.
REQ-012 mem_ready  input  1  access completes on a clk edge where mem_req = 1 and mem_ready = 1.
REQ-013 pc  output  32  current PC register.
REQ-014 state  output  4  current FSM state encoding, for debug.
REQ-015 halted  output  1  1 while the FSM is in HALT.

Function
REQ-016 The block is a multicycle MIPS datapath plus controller: one unified memory port; internal IR, MDR, A, B, ALUOut registers; 32x32 register file; ALU.
REQ-017 Supported instructions: R-type (op 0) add/sub/and/or/slt (funct 20/22/24/25/2A hex), lw (23), sw (2B), beq (04), addi (08), j (02).
REQ-018 FSM states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, HALT=15.
REQ-019 FETCH: mem_req = 1, mem_we = 0, mem_addr = pc; the FSM stays in FETCH until mem_ready; on completion IR <= mem_rdata, pc <= pc+4, next state DECODE.
REQ-020 DECODE (1 cycle): A <= rf[rs], B <= rf[rt], ALUOut <= pc + (sign-extended imm << 2); the next state is selected by opcode.
REQ-021 lw/sw: MEMADR computes ALUOut <= A + sign-extended imm. lw then goes MEMRD -> MEMWB; sw goes to MEMWR.
REQ-022 MEMRD holds a read at ALUOut until mem_ready, then MDR <= mem_rdata. MEMWB writes rf[rt] <= MDR, then goes to FETCH.
REQ-023 MEMWR holds mem_we = 1, mem_addr = ALUOut, mem_wdata = B until mem_ready, then goes to FETCH.
REQ-024 R-type: EXEC computes ALUOut <= A op B; ALUWB writes rf[rd] <= ALUOut, then goes to FETCH.
REQ-025 addi: ADDIEX computes ALUOut <= A + sign-extended imm; ADDIWB writes rf[rt], then goes to FETCH.
REQ-026 BRANCH (1 cycle): if A == B then pc <= ALUOut; next state is FETCH.
REQ-027 JUMP (1 cycle): pc <= {pc[31:28], IR[25:0], 2'b00}, using the already-incremented pc; next state is FETCH.
REQ-028 Arithmetic wraps modulo 2^32; no overflow trap. slt is a signed compare and yields 1 or 0.
REQ-029 rf[0] always reads 0; writes to register 0 are discarded.
REQ-030 mem_req = 0 in all states other than FETCH, MEMRD and MEMWR. mem_addr, mem_we and mem_wdata stay stable while mem_req = 1 and mem_ready = 0.
REQ-031 Illegal opcode or funct: the FSM enters HALT when TRAP_ON_ILLEGAL = 1, otherwise goes to FETCH. HALT is exited only by reset.
REQ-032 CPI: R-type 4, addi 4, beq 3, j 3, sw 4, lw 5, each plus memory wait cycles.

Reset
REQ-033 Reset assertion, at any time including mid-access: state <= FETCH, pc <= RESET_PC, IR/MDR/A/B/ALUOut <= 0, all rf entries <= 0.
REQ-034 During reset: mem_req = 0, mem_we = 0, halted = 0. The first fetch request appears in the first cycle after reset deassertion.

Verification
REQ-035 Zero-wait memory, program "addi $1,$0,5; addi $2,$0,7; add $3,$1,$2" -> $3 = 12 after 12 cycles; pc = 0x0C.
REQ-036 sw $3,0x40($0) then lw $4,0x40($0), with mem_ready delayed 3 cycles per access -> write at addr 0x40 with data 12, request held stable for 4 cycles; $4 = 12.
REQ-037 beq $1,$1,-1 at 0x10 -> pc returns to 0x10 every 3 cycles. beq $1,$2 with unequal operands -> pc = 0x14.
REQ-038 j 0x0000100 at pc 0x20 -> pc = 0x400. slt $5,$6,$7 with $6 = 0xFFFFFFFF and $7 = 1 -> $5 = 1. addi $0,$0,9 -> $0 reads 0.
REQ-039 Opcode 0x3F with TRAP_ON_ILLEGAL = 1 -> halted = 1, state = 15, mem_req stays 0; with TRAP_ON_ILLEGAL = 0 -> next fetch at pc+4.
REQ-040 Reset asserted mid-MEMRD while mem_ready = 0 -> mem_req drops asynchronously; after release the FSM fetches from RESET_PC = 0x0000_0100 (parameter override).
